// File: rtl/vip_capture_scheduler.sv
// rtl/vip_capture_scheduler.sv - round-robin single-frame capture from three VIP taps onto one frame-buffer write port
module vip_capture_scheduler #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int ADDR_W    = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        tap_mask,
  input  logic [2:0]        tap_vsync,
  input  logic [2:0]        tap_href,
  input  logic [2:0]        tap_clken,
  input  logic [23:0]       tap_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [1:0]        wr_tap,
  output logic              busy,
  output logic              done,
  output logic [2:0]        err,
  output logic [ADDR_W-1:0] frame_pixels
);
  localparam int FRAME = IMG_HDISP * IMG_VDISP;
  localparam logic [ADDR_W-1:0] FRAME_A = ADDR_W'(FRAME);

  typedef enum logic [1:0] {IDLE, ARM, CAP, NEXT} state_t;
  state_t state, state_n;

  logic [2:0]        mask, mask_n, vs_d, rise, fall, err_n;
  logic [1:0]        cur, cur_n, wr_tap_n, first_bit, next_bit;
  logic              has_next, pix_ok;
  logic [ADDR_W-1:0] pix_cnt, pix_cnt_n, wr_addr_n, frame_pixels_n, base, cnt_final;
  logic [7:0]        wr_data_n, cur_data;
  logic              wr_en_n, busy_n, done_n;

  assign rise     = tap_vsync & ~vs_d;
  assign fall     = ~tap_vsync & vs_d;
  assign pix_ok   = tap_href[cur] & tap_clken[cur];
  assign cur_data = tap_data[{cur, 3'b000} +: 8];

  assign first_bit = tap_mask[0] ? 2'd0 : (tap_mask[1] ? 2'd1 : 2'd2);

  always_comb begin
    has_next = 1'b0;
    next_bit = cur;
    case (cur)
      2'd0: begin
        if (mask[1]) begin has_next = 1'b1; next_bit = 2'd1; end
        else if (mask[2]) begin has_next = 1'b1; next_bit = 2'd2; end
      end
      2'd1: if (mask[2]) begin has_next = 1'b1; next_bit = 2'd2; end
      default: has_next = 1'b0;
    endcase
  end

  always_comb begin
    case (cur)
      2'd0:    base = '0;
      2'd1:    base = FRAME_A;
      default: base = FRAME_A + FRAME_A;
    endcase
  end

  always_comb begin
    state_n        = state;
    mask_n         = mask;
    cur_n          = cur;
    pix_cnt_n      = pix_cnt;
    err_n          = err;
    frame_pixels_n = frame_pixels;
    busy_n         = busy;
    done_n         = 1'b0;
    wr_en_n        = 1'b0;
    wr_addr_n      = wr_addr;
    wr_data_n      = wr_data;
    wr_tap_n       = wr_tap;
    cnt_final      = pix_cnt;
    // abort outranks any same-cycle vsync edge or pixel
    if (abort && state != IDLE) begin
      state_n = IDLE;
      busy_n  = 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mask_n = tap_mask;
          err_n  = '0;
          if (tap_mask == 3'b000) begin
            done_n = 1'b1;
          end else begin
            cur_n   = first_bit;
            state_n = ARM;
            busy_n  = 1'b1;
          end
        end
        ARM: if (rise[cur]) begin
          pix_cnt_n = '0;
          state_n   = CAP;
        end
        CAP: begin
          if (pix_ok) begin
            if (pix_cnt < FRAME_A) begin
              wr_en_n   = 1'b1;
              wr_addr_n = base + pix_cnt;
              wr_data_n = cur_data;
              wr_tap_n  = cur;
              pix_cnt_n = pix_cnt + ADDR_W'(1);
              cnt_final = pix_cnt + ADDR_W'(1);
            end else begin
              err_n[cur] = 1'b1;
            end
          end
          if (fall[cur]) begin
            frame_pixels_n = cnt_final;
            if (cnt_final != FRAME_A) err_n[cur] = 1'b1;
            state_n = NEXT;
          end
        end
        NEXT: begin
          if (has_next) begin
            cur_n   = next_bit;
            state_n = ARM;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mask         <= '0;
      cur          <= '0;
      pix_cnt      <= '0;
      vs_d         <= '0;
      err          <= '0;
      frame_pixels <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      wr_tap       <= '0;
    end else begin
      state        <= state_n;
      mask         <= mask_n;
      cur          <= cur_n;
      pix_cnt      <= pix_cnt_n;
      vs_d         <= tap_vsync;
      err          <= err_n;
      frame_pixels <= frame_pixels_n;
      busy         <= busy_n;
      done         <= done_n;
      wr_en        <= wr_en_n;
      wr_addr      <= wr_addr_n;
      wr_data      <= wr_data_n;
      wr_tap       <= wr_tap_n;
    end
  end
endmodule

// File: tb/tb_vip_capture_scheduler.sv
// tb/tb_vip_capture_scheduler.sv - scoreboard bench for vip_capture_scheduler on an 8x4 image
module tb_vip_capture_scheduler;
  localparam int H = 8, V = 4, AW = 20, FRAME = H * V;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [2:0]    tap_mask, tap_vsync, tap_href, tap_clken;
  logic [23:0]   tap_data;
  logic          wr_en, busy, done;
  logic [AW-1:0] wr_addr, frame_pixels;
  logic [7:0]    wr_data;
  logic [1:0]    wr_tap;
  logic [2:0]    err;

  int n_checks = 0, n_pass = 0, done_cnt = 0, d0;
  logic [29:0] sb[$];

  vip_capture_scheduler #(.IMG_HDISP(H), .IMG_VDISP(V), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .tap_mask(tap_mask),
    .tap_vsync(tap_vsync), .tap_href(tap_href), .tap_clken(tap_clken), .tap_data(tap_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_tap(wr_tap),
    .busy(busy), .done(done), .err(err), .frame_pixels(frame_pixels)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // every write must match the oldest expected pixel
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (wr_en) begin
      check("wr_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0)
        check("wr_tap_addr_data", {2'b00, wr_tap, wr_addr, wr_data}, {2'b00, sb.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    start     = 1'b0;
    abort     = 1'b0;
    tap_href  = '0;
    tap_clken = '0;
  endtask

  task automatic do_start(input logic [2:0] m);
    tap_mask = m;
    start    = 1'b1;
    step();
  endtask

  task automatic send_frame(input int tap, input int npix, input bit cap,
                            input int start_at, input int abort_at);
    int idx = 0;
    repeat (3) step();
    tap_vsync[tap] = 1'b1;
    step();
    step();
    while (idx < npix) begin
      for (int c = 0; c < H && idx < npix; c++) begin
        tap_href[tap]  = 1'b1;
        tap_clken[tap] = 1'b1;
        tap_data[8*tap +: 8] = 8'(16 * tap + idx);
        if (idx == start_at) start = 1'b1;
        if (idx == abort_at) abort = 1'b1;
        if (cap && idx < FRAME && (abort_at < 0 || idx < abort_at))
          sb.push_back({2'(tap), 20'(tap * FRAME + idx), 8'(16 * tap + idx)});
        step();
        if (idx == abort_at) begin
          check("busy_after_abort", 32'(busy), 32'd0);
          check("done_after_abort", 32'(done), 32'd0);
        end
        idx++;
      end
      step();
    end
    tap_vsync[tap] = 1'b0;
    step();
  endtask

  task automatic finish_run(input string tag, input int exp_done, input logic [2:0] exp_err,
                            input int exp_fp);
    repeat (4) step();
    check({tag, "_done"}, 32'(done_cnt - d0), 32'(exp_done));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_fp"}, 32'(frame_pixels), 32'(exp_fp));
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; tap_mask = '0;
    tap_vsync = '0; tap_href = '0; tap_clken = '0; tap_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_flags", {22'd0, wr_en, busy, done, err, wr_tap, 1'b0}, 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_fp", 32'(frame_pixels), 32'd0);
    rst = 1'b0;
    step();

    // all three taps, clean frames
    d0 = done_cnt;
    do_start(3'b111);
    check("all_busy", 32'(busy), 32'd1);
    for (int t = 0; t < 3; t++) send_frame(t, 32, 1'b1, -1, -1);
    finish_run("all", 1, 3'b000, 32);

    // start mid-frame on tap0: partial frame ignored
    d0 = done_cnt;
    tap_mask = 3'b001;
    send_frame(0, 32, 1'b0, 12, -1);
    check("mid_busy", 32'(busy), 32'd1);
    send_frame(0, 32, 1'b1, -1, -1);
    finish_run("mid", 1, 3'b000, 32);

    // taps 0 and 2 only; tap1 traffic ignored
    d0 = done_cnt;
    do_start(3'b101);
    send_frame(0, 32, 1'b1, -1, -1);
    send_frame(1, 32, 1'b0, -1, -1);
    send_frame(2, 32, 1'b1, -1, -1);
    finish_run("m101", 1, 3'b000, 32);

    // short then long frame on tap1
    d0 = done_cnt;
    do_start(3'b010);
    send_frame(1, 31, 1'b1, -1, -1);
    finish_run("short", 1, 3'b010, 31);
    d0 = done_cnt;
    do_start(3'b010);
    send_frame(1, 34, 1'b1, -1, -1);
    finish_run("long", 1, 3'b010, 32);

    // abort during tap1 capture, then a full restart
    d0 = done_cnt;
    do_start(3'b111);
    check("abort_err_cleared", 32'(err), 32'd0);
    send_frame(0, 32, 1'b1, -1, -1);
    send_frame(1, 32, 1'b1, -1, 10);
    send_frame(2, 32, 1'b0, -1, -1);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);
    d0 = done_cnt;
    do_start(3'b111);
    for (int t = 0; t < 3; t++) send_frame(t, 32, 1'b1, -1, -1);
    finish_run("restart", 1, 3'b000, 32);

    // empty mask, then start while busy
    do_start(3'b000);
    check("m0_done", 32'(done), 32'd1);
    check("m0_busy", 32'(busy), 32'd0);
    step();
    check("m0_done_off", 32'(done), 32'd0);
    check("m0_busy_off", 32'(busy), 32'd0);
    d0 = done_cnt;
    do_start(3'b001);
    do_start(3'b110);
    send_frame(1, 32, 1'b0, -1, -1);
    send_frame(0, 32, 1'b1, -1, -1);
    send_frame(2, 32, 1'b0, -1, -1);
    finish_run("busy_start", 1, 3'b000, 32);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/vip_capture_scheduler.md
Name: vip_capture_scheduler

Overview:
- Shares one frame-buffer write port between the three VIP pipeline tap points: YCbCr Y output (tap 0), Gaussian output (tap 1) and Canny output (tap 2, bit expanded to 8 bits upstream).
- On `start`, captures exactly one complete frame from each enabled tap, in round-robin order 0→1→2, into disjoint buffer regions.
- Flags frames whose pixel count is wrong.
- Sits between the VIP pipeline outputs and the frame-buffer/BMP writer.

Parameters:
- IMG_HDISP, 640, active pixels per line
- IMG_VDISP, 480, active lines per frame
- ADDR_W, 20, write address width; must hold 3*IMG_HDISP*IMG_VDISP-1

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle capture request
- abort  in  1  cancel the capture in progress
- tap_mask  in  3  enabled taps; bit i = tap i; sampled on accepted start
- tap_vsync  in  3  per-tap frame valid; high = active frame
- tap_href  in  3  per-tap line valid
- tap_clken  in  3  per-tap pixel enable
- tap_data  in  24  tap i pixel on bits [8i+7:8i]
- wr_en  out  1  frame-buffer write strobe
- wr_addr  out  ADDR_W  write address
- wr_data  out  8  write data
- wr_tap  out  2  tap id of the current write
- busy  out  1  high from accepted start until return to IDLE
- done  out  1  one-cycle pulse when the sequence ends
- err  out  3  sticky per-tap pixel-count error; cleared on accepted start
- frame_pixels  out  ADDR_W  pixel count of the last closed frame

Behaviour:
- Reset: every output is 0; state = IDLE; internal mask, counters and vsync history registers are 0.
- Constants:
  - FRAME = IMG_HDISP*IMG_VDISP
  - base(i) = i*FRAME
- Edge detection:
  - vs_d[i] is the registered tap_vsync[i], updated every cycle in every state.
  - Rising edge = tap_vsync & ~vs_d.
  - Falling edge = ~tap_vsync & vs_d.
- States:
  - IDLE: start latches tap_mask and clears err.
    - Mask == 0: done pulses on the next cycle, no writes, busy stays 0.
    - Otherwise: cur = lowest set mask bit; go to ARM; busy = 1.
  - ARM: wait for a rising edge of tap_vsync[cur].
    - A start that lands mid-frame (vsync already high) waits for the next frame.
    - On the edge: pix_cnt = 0; go to CAP.
    - Pixels in the edge cycle itself are not captured.
  - CAP: each cycle with tap_href[cur] & tap_clken[cur]:
    - If pix_cnt < FRAME, write the pixel and increment pix_cnt.
    - Once pix_cnt == FRAME, further pixels are dropped and err[cur] is set (overrun).
  - CAP, on a falling edge of tap_vsync[cur]:
    - A qualifying pixel in the same cycle is still written and counted.
    - frame_pixels is loaded with the final count.
    - If the final count != FRAME, err[cur] is set (short frame).
    - Go to NEXT.
  - NEXT: cur = next set mask bit above cur.
    - If one exists: go to ARM.
    - If none: go to IDLE; done pulses for one cycle; busy drops in the same cycle.
- Write timing:
  - Registered, latency 1: the pixel sampled at edge N appears at edge N+1 as wr_en = 1, wr_addr = base(cur)+pix_cnt, wr_data = that tap's byte, wr_tap = cur.
  - wr_en is 0 on all other cycles.
- Other taps: traffic on non-selected taps is ignored in all states.
- start while busy is ignored; the mask and err are unchanged.
- abort in ARM, CAP or NEXT:
  - Next state is IDLE; busy = 0 the next cycle.
  - No done pulse; err keeps its value; a write already registered still completes.
  - abort has priority over a same-cycle vsync edge; the edge is neither processed nor recorded.
- Arithmetic:
  - pix_cnt is ADDR_W bits and never wraps; it saturates at FRAME.
  - Addresses never leave [base(cur), base(cur)+FRAME-1].
- rst asserted mid-capture: outputs are 0 on the next cycle; no further writes.

Test Plan (IMG_HDISP=8, IMG_VDISP=4, FRAME=32, synthetic timing generator per tap):
- mask=3'b111, clean frames, tap i data = 8'h10*i + pixel index:
  - 96 writes; tap0 addr 0–31, tap1 32–63, tap2 64–95; data matches.
  - done pulses once; err=0; frame_pixels=32.
- start issued mid-frame on tap0 (vsync high, pixel 12 of 32):
  - No writes until the next rising edge; then 32 writes at addr 0–31.
  - No pixels from the partial frame appear.
- mask=3'b101:
  - tap0 → addr 0–31, then tap2 → addr 64–95.
  - No writes to 32–63; wr_tap is only 0 or 2.
- tap1 frame with 31 pixels, then tap1 frame with 34 pixels (two runs, mask=3'b010):
  - First run: err=3'b010, frame_pixels=31.
  - Second run: exactly 32 writes (addr 32–63), err=3'b010, frame_pixels=32.
- abort during tap1 CAP, then start again:
  - After abort: busy=0 the next cycle, no done.
  - Restart: err cleared; a full sequence completes normally.
- start with mask=0: done pulses 1 cycle later, busy never rises, wr_en stays 0; a start during busy has no effect.
